load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's ALU/control stage and the word-organised data memory.
- Accepts one load or store per instruction: ALU result is the byte address, funct3 selects the access size.
- Drives a request/grant/response handshake to a memory with variable latency. Generates byte enables and aligned store data. Sign- or zero-extends load data.
- Stalls the core until the access completes. Reports misaligned accesses and response timeouts.

Parameters:
ADDR_W, 6, word-address width presented to memory (64-word memory)
TIMEOUT, 16, max cycles in WAIT before bus error (legal range 2..255)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
mem_read  in  1  load requested (from control unit)
mem_write  in  1  store requested (from control unit)
funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU
addr  in  32  byte address (ALU result)
wdata  in  32  store data (rs2)
stall  out  1  core must hold PC and inputs while high
done  out  1  one-cycle pulse: access finished
load_data  out  32  extended load result, valid while done=1
misalign_err  out  1  one-cycle pulse with done: misaligned access
bus_err  out  1  one-cycle pulse with done: response timeout
mem_req  out  1  memory request
mem_we  out  1  1=write, 0=read
mem_be  out  4  byte enables, bit i = byte lane i
mem_addr  out  ADDR_W  word address = addr[ADDR_W+1:2]
mem_wdata  out  32  lane-aligned store data
mem_gnt  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data / write ack valid
mem_rdata  in  32  read word

Behaviour:
- Reset clears everything: state=IDLE; all outputs 0; latched request regs 0; timeout counter 0. Reset mid-access aborts immediately with no done pulse.
- The core holds mem_read, mem_write, funct3, addr and wdata stable while stall=1.
- States: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If mem_read|mem_write=1, latch funct3/addr/wdata/we. If both are high, mem_write wins.
  - Alignment check: H/HU need addr[0]=0; W needs addr[1:0]=00.
  - Misaligned: go to DONE with misalign_err set; no memory request is issued.
  - Aligned: go to REQ.
  - stall = mem_read|mem_write, combinational in IDLE.
- REQ:
  - mem_req=1. mem_we, mem_be, mem_addr and mem_wdata come from registers and are stable until gnt.
  - mem_gnt=1: go to WAIT, clear the counter. Otherwise stay.
  - Unbounded wait for grant is allowed. stall=1.
- WAIT:
  - mem_req=0, stall=1, counter increments each cycle.
  - mem_rvalid=1: capture mem_rdata, go to DONE. The write ack carries no data.
  - Counter reaches TIMEOUT-1 with no rvalid: go to DONE with bus_err=1 and load_data=0.
  - rvalid arriving on the same cycle as the timeout: rvalid wins, no error.
- DONE:
  - done=1 and stall=0 for exactly one cycle; error flags are valid this cycle; next state IDLE.
  - The core advances on this edge, so a new op is seen no earlier than the following IDLE cycle.
  - Best-case latency, grant in the REQ cycle and rvalid the cycle after: IDLE, REQ, WAIT, DONE = 4 cycles, 3 stall cycles.
- Byte enables, with o = addr[1:0]:
  - B: 0001<<o
  - H: 0011<<o
  - W: 1111
- Store data:
  - B: wdata[7:0] replicated to all 4 lanes
  - H: wdata[15:0] replicated to both halves
  - W: wdata unchanged
- Load extraction: select the byte or half at lane o from the captured word. B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- mem_rvalid seen outside WAIT is ignored.
- mem_be=0 whenever mem_req=0.
- Unsupported funct3 (011, 110, 111) is treated as W.
- Address bits above ADDR_W+1 are ignored; mem_addr wraps modulo 2^ADDR_W words.

Test Plan:
- SW, addr=0x8, wdata=0xDEADBEEF; gnt on the first REQ cycle, rvalid 1 cycle later -> mem_addr=2, mem_be=1111, mem_wdata=0xDEADBEEF; done at cycle 4; stall high for 3 cycles.
- LB, addr=0x9, mem_rdata=0x12348056 -> mem_be=0010; load_data=0xFFFFFF80. Repeat as LBU -> 0x00000080.
- LH, addr=0xE, mem_rdata=0x9ABC1234 -> mem_be=1100, load_data=0xFFFF9ABC. Repeat as SH, addr=0x2, wdata=0x0000A5A5 -> mem_be=1100, mem_wdata=0xA5A5A5A5.
- LW at addr=0x6 -> no mem_req ever; done and misalign_err together in the 2nd cycle; load_data=0.
- Grant delayed 3 cycles, then no rvalid -> mem_req held for 3 cycles; bus_err with done exactly TIMEOUT cycles after entering WAIT. Separately, rvalid on the final timeout cycle -> no bus_err.
- Assert reset during WAIT -> outputs go to 0 immediately; no done pulse; a following LW completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: word-organised memory over a req/gnt/rvalid handshake, with byte enables,
// lane-aligned store data, sign/zero-extended loads, and misalign/timeout reporting.
module load_store_unit #(
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic [31:0]       load_data,
    output logic              misalign_err,
    output logic              bus_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} state_e;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       ld_q, ld_d;
    logic              mis_q, mis_d;
    logic              berr_q, berr_d;

    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        misaligned;
    logic [7:0]  rd_byte;
    logic [15:0] rd_half;
    logic [31:0] rd_ext;
    logic        unused_addr;

    assign unused_addr = ^addr[31:ADDR_W+2];

    // Size decode of the incoming op; funct3[1:0] of 11 falls through to word.
    always_comb begin
        req_be     = 4'b1111;
        req_wdata  = wdata;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                req_be    = 4'b0001 << addr[1:0];
                req_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                req_be     = 4'b0011 << addr[1:0];
                req_wdata  = {2{wdata[15:0]}};
                misaligned = addr[0];
            end
            default: misaligned = |addr[1:0];
        endcase
    end

    always_comb begin
        rd_byte = mem_rdata[{off_q, 3'b000} +: 8];
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (f3_q[1:0])
            2'b00:   rd_ext = f3_q[2] ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   rd_ext = f3_q[2] ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: rd_ext = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        f3_d    = f3_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        mis_d   = mis_q;
        berr_d  = berr_q;
        unique case (state_q)
            StIdle: begin
                if (mem_read || mem_write) begin
                    we_d    = mem_write;
                    f3_d    = funct3;
                    off_d   = addr[1:0];
                    waddr_d = addr[ADDR_W+1:2];
                    be_d    = req_be;
                    wdata_d = req_wdata;
                    ld_d    = 32'h0;
                    mis_d   = misaligned;
                    berr_d  = 1'b0;
                    state_d = misaligned ? StDone : StReq;
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    cnt_d   = 8'h0;
                    state_d = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_q + 8'h1;
                // A response on the final cycle still counts as success.
                if (mem_rvalid) begin
                    ld_d    = we_q ? 32'h0 : rd_ext;
                    state_d = StDone;
                end else if (cnt_q == CntLast) begin
                    ld_d    = 32'h0;
                    berr_d  = 1'b1;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'h0;
            off_q   <= 2'h0;
            waddr_q <= '0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'h0;
            ld_q    <= 32'h0;
            mis_q   <= 1'b0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            mis_q   <= mis_d;
            berr_q  <= berr_d;
        end
    end

    always_comb begin
        stall        = 1'b0;
        done         = 1'b0;
        load_data    = 32'h0;
        misalign_err = 1'b0;
        bus_err      = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_be       = 4'h0;
        mem_addr     = '0;
        mem_wdata    = 32'h0;
        unique case (state_q)
            StIdle: stall = (mem_read | mem_write) & ~reset;
            StReq: begin
                stall     = 1'b1;
                mem_req   = 1'b1;
                mem_we    = we_q;
                mem_be    = be_q;
                mem_addr  = waddr_q;
                mem_wdata = wdata_q;
            end
            StWait: stall = 1'b1;
            StDone: begin
                done         = 1'b1;
                load_data    = ld_q;
                misalign_err = mis_q;
                bus_err      = berr_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a small memory responder with programmable grant and
// response delays, hand-computed expectations per vector.
module tb_load_store_unit;

    localparam int unsigned ADDR_W  = 6;
    localparam int unsigned TIMEOUT = 16;

    logic              clk, reset;
    logic              mem_read, mem_write;
    logic [2:0]        funct3;
    logic [31:0]       addr, wdata;
    logic              stall, done, misalign_err, bus_err;
    logic [31:0]       load_data;
    logic              mem_req, mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_gnt, mem_rvalid;
    logic [31:0]       mem_rdata;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .wdata        (wdata),
        .stall        (stall),
        .done         (done),
        .load_data    (load_data),
        .misalign_err (misalign_err),
        .bus_err      (bus_err),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_be       (mem_be),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    int              r_done_n, r_stall_n, r_req_n;
    logic [3:0]      r_be;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]     r_wdata, r_ld;
    logic            r_we, r_mis, r_berr, r_be_leak;

    // Issue one op at posedge+1; grant on the gnt_at-th REQ cycle, rvalid on the rv_at-th
    // WAIT cycle (0 = never). Returns with the op deasserted in the IDLE cycle after DONE.
    task automatic run_op(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input int gnt_at, input int rv_at,
                          input logic [31:0] rd);
        int n, w;
        logic granted;
        mem_read  = !wr;
        mem_write = wr;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        mem_rdata = rd;
        n = 0; w = 0; granted = 1'b0;
        r_done_n = -1; r_stall_n = 0; r_req_n = 0; r_be = 0; r_addr = 0; r_wdata = 0;
        r_ld = 0; r_we = 0; r_mis = 0; r_berr = 0; r_be_leak = 0;
        while (n < 300) begin
            @(negedge clk);
            n++;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (stall) r_stall_n++;
            if (!mem_req && mem_be != 4'h0) r_be_leak = 1'b1;
            if (done) begin
                r_done_n = n;
                r_ld     = load_data;
                r_mis    = misalign_err;
                r_berr   = bus_err;
                break;
            end
            if (mem_req) begin
                r_req_n++;
                r_be    = mem_be;
                r_addr  = mem_addr;
                r_wdata = mem_wdata;
                r_we    = mem_we;
                if (r_req_n == gnt_at) begin
                    mem_gnt = 1'b1;
                    granted = 1'b1;
                end
            end else if (granted) begin
                w++;
                if (w == rv_at) mem_rvalid = 1'b1;
            end
        end
        if (r_done_n < 0) check("done_seen", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    int done_cnt;

    initial begin
        reset = 1'b1;
        mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
        #2;
        check("rst_outputs", {stall, done, misalign_err, bus_err, mem_req, mem_we, mem_be},
              32'h0);
        check("rst_load_data", load_data, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // SW, best case
        run_op(1'b1, 3'b010, 32'h8, 32'hDEADBEEF, 1, 1, 32'h0);
        check("sw_done_cycle", r_done_n, 4);
        check("sw_stall_cycles", r_stall_n, 3);
        check("sw_addr", r_addr, 2);
        check("sw_be", r_be, 4'b1111);
        check("sw_wdata", r_wdata, 32'hDEADBEEF);
        check("sw_we", r_we, 1);
        check("sw_flags", {r_mis, r_berr}, 0);
        check("sw_be_idle", r_be_leak, 0);

        run_op(1'b0, 3'b000, 32'h9, 32'h0, 1, 1, 32'h12348056);
        check("lb_be", r_be, 4'b0010);
        check("lb_we", r_we, 0);
        check("lb_data", r_ld, 32'hFFFFFF80);

        run_op(1'b0, 3'b100, 32'h9, 32'h0, 1, 1, 32'h12348056);
        check("lbu_data", r_ld, 32'h00000080);

        run_op(1'b0, 3'b001, 32'hE, 32'h0, 1, 1, 32'h9ABC1234);
        check("lh_be", r_be, 4'b1100);
        check("lh_addr", r_addr, 3);
        check("lh_data", r_ld, 32'hFFFF9ABC);

        run_op(1'b1, 3'b001, 32'h2, 32'h0000A5A5, 1, 1, 32'h0);
        check("sh_be", r_be, 4'b1100);
        check("sh_wdata", r_wdata, 32'hA5A5A5A5);

        run_op(1'b1, 3'b000, 32'h3, 32'h00000077, 1, 2, 32'h0);
        check("sb_be", r_be, 4'b1000);
        check("sb_wdata", r_wdata, 32'h77777777);
        check("sb_done_cycle", r_done_n, 5);

        run_op(1'b0, 3'b101, 32'h2, 32'h0, 1, 1, 32'h80001234);
        check("lhu_data", r_ld, 32'h00008000);

        // funct3=011 behaves as word; address wraps modulo 64 words
        run_op(1'b0, 3'b011, 32'h104, 32'h0, 1, 1, 32'h89ABCDEF);
        check("f3_011_be", r_be, 4'b1111);
        check("wrap_addr", r_addr, 1);
        check("f3_011_data", r_ld, 32'h89ABCDEF);

        run_op(1'b0, 3'b010, 32'h6, 32'h0, 1, 1, 32'h12345678);
        check("mis_done_cycle", r_done_n, 2);
        check("mis_req_cycles", r_req_n, 0);
        check("mis_err", r_mis, 1);
        check("mis_load_data", r_ld, 32'h0);

        run_op(1'b0, 3'b010, 32'h10, 32'h0, 3, 0, 32'h55555555);
        check("to_req_cycles", r_req_n, 3);
        check("to_done_cycle", r_done_n, 1 + 3 + TIMEOUT + 1);
        check("to_bus_err", r_berr, 1);
        check("to_load_data", r_ld, 32'h0);

        run_op(1'b0, 3'b010, 32'h10, 32'h0, 1, TIMEOUT, 32'h11223344);
        check("late_rv_done_cycle", r_done_n, 1 + 1 + TIMEOUT + 1);
        check("late_rv_bus_err", r_berr, 0);
        check("late_rv_data", r_ld, 32'h11223344);

        // Reset during WAIT
        mem_read = 1'b1; funct3 = 3'b010; addr = 32'h20; mem_rdata = 32'hCAFEF00D;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid_req", mem_req, 1);
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        @(negedge clk);
        check("rst_mid_wait_stall", stall, 1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_outputs", {stall, done, misalign_err, bus_err, mem_req, mem_we, mem_be},
              32'h0);
        check("rst_mid_load_data", load_data, 32'h0);
        @(negedge clk);
        reset    = 1'b0;
        mem_read = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
        check("rst_no_done", done_cnt, 0);
        @(posedge clk);
        #1;
        run_op(1'b0, 3'b010, 32'h20, 32'h0, 1, 1, 32'hCAFEF00D);
        check("post_rst_done_cycle", r_done_n, 4);
        check("post_rst_data", r_ld, 32'hCAFEF00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
